// File: rtl/input_conditioner_if.sv
// Raw asynchronous inputs and conditioned outputs of the input conditioner.
// The master side drives the raw inputs; the slave side is the conditioner itself.
interface input_conditioner_if;
   logic sensor;
   logic walk_request;
   logic reprogram;
   logic sensor_sync;
   logic walk_request_sync;
   logic reprogram_sync;

   modport master (
      output sensor, walk_request, reprogram,
      input  sensor_sync, walk_request_sync, reprogram_sync
   );

   modport slave (
      input  sensor, walk_request, reprogram,
      output sensor_sync, walk_request_sync, reprogram_sync
   );
endinterface

// File: rtl/input_conditioner.sv
// Two-flop synchroniser plus per-channel debounce FSM for sensor, walk and reprogram inputs.
// Channel 0 (sensor) yields a debounced level; channels 1/2 yield one pulse per accepted press.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input_conditioner_if.slave   io
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONF_HI = 2'd1,
      HIGH    = 2'd2,
      CONF_LO = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [2:0]       raw_s;
   logic [2:0]       s1_r;
   logic [2:0]       s2_r;
   state_t           state_r     [3];
   state_t           state_nxt_s [3];
   logic [CNT_W-1:0] cnt_r       [3];
   logic [CNT_W-1:0] cnt_nxt_s   [3];
   logic             sensor_sync_r;
   logic             walk_sync_r;
   logic             reprogram_sync_r;

   assign raw_s = {io.reprogram, io.walk_request, io.sensor};

   // Two-stage synchroniser for all three raw inputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_r <= 3'b000;
         s2_r <= 3'b000;
      end else begin
         s1_r <= raw_s;
         s2_r <= s1_r;
      end
   end

   // Debounce next-state and counter logic, one identical FSM per channel
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         state_nxt_s[i] = state_r[i];
         cnt_nxt_s[i]   = cnt_r[i];
         case (state_r[i])
            IDLE: begin
               if (s2_r[i]) begin
                  state_nxt_s[i] = CONF_HI;
                  cnt_nxt_s[i]   = CNT_ONE;
               end else begin
                  cnt_nxt_s[i]   = CNT_ZERO;
               end
            end
            CONF_HI: begin
               if (!s2_r[i]) begin
                  state_nxt_s[i] = IDLE;
                  cnt_nxt_s[i]   = CNT_ZERO;
               end else if (cnt_r[i] == CNT_LAST) begin
                  state_nxt_s[i] = HIGH;
                  cnt_nxt_s[i]   = CNT_ZERO;
               end else begin
                  cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
               end
            end
            HIGH: begin
               if (!s2_r[i]) begin
                  state_nxt_s[i] = CONF_LO;
                  cnt_nxt_s[i]   = CNT_ONE;
               end else begin
                  state_nxt_s[i] = HIGH;
               end
            end
            CONF_LO: begin
               if (s2_r[i]) begin
                  state_nxt_s[i] = HIGH;
                  cnt_nxt_s[i]   = CNT_ZERO;
               end else if (cnt_r[i] == CNT_LAST) begin
                  state_nxt_s[i] = IDLE;
                  cnt_nxt_s[i]   = CNT_ZERO;
               end else begin
                  cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
               end
            end
            default: begin
               state_nxt_s[i] = IDLE;
               cnt_nxt_s[i]   = CNT_ZERO;
            end
         endcase
      end
   end

   // FSM state and counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) begin
            state_r[i] <= IDLE;
            cnt_r[i]   <= CNT_ZERO;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            state_r[i] <= state_nxt_s[i];
            cnt_r[i]   <= cnt_nxt_s[i];
         end
      end
   end

   // Outputs are registered from the transition itself so they appear the cycle the FSM enters HIGH
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sensor_sync_r    <= 1'b0;
         walk_sync_r      <= 1'b0;
         reprogram_sync_r <= 1'b0;
      end else begin
         sensor_sync_r    <= (state_nxt_s[0] == HIGH) || (state_nxt_s[0] == CONF_LO);
         walk_sync_r      <= (state_r[1] == CONF_HI) && (state_nxt_s[1] == HIGH);
         reprogram_sync_r <= (state_r[2] == CONF_HI) && (state_nxt_s[2] == HIGH);
      end
   end

   assign io.sensor_sync       = sensor_sync_r;
   assign io.walk_request_sync = walk_sync_r;
   assign io.reprogram_sync    = reprogram_sync_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4: a sample-history model
// checked every cycle, plus hand-computed latency and pulse-count expectations.
module tb_input_conditioner;

   localparam int D = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   input_conditioner_if io ();

   input_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int walk_pulses = 0;
   int rep_pulses  = 0;

   // Model: a channel's level flips once the last D synchronised samples all disagree with it.
   // The FSM at edge n sees the raw value sampled at edge n-2; reset makes those samples 0.
   bit hist [3][$];
   bit m_level [3];
   bit m_pulse [3];

   always @(posedge clk or negedge reset) begin
      bit raw_v [3];
      bit flip;
      int sz;
      if (!reset) begin
         for (int c = 0; c < 3; c++) begin
            hist[c].delete();
            repeat (D + 2) hist[c].push_back(1'b0);
            m_level[c] <= 1'b0;
            m_pulse[c] <= 1'b0;
         end
      end else begin
         raw_v = '{io.sensor, io.walk_request, io.reprogram};
         for (int c = 0; c < 3; c++) begin
            hist[c].push_back(raw_v[c]);
            if (hist[c].size() > 4 * D) void'(hist[c].pop_front());
            sz   = hist[c].size();
            flip = 1'b1;
            for (int k = 0; k < D; k++)
               if (hist[c][sz - 3 - k] == m_level[c]) flip = 1'b0;
            m_pulse[c] <= flip && !m_level[c];
            m_level[c] <= flip ? !m_level[c] : m_level[c];
         end
      end
   end

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
      end
   endtask

   // Advance n clock edges; compare DUT against the model 1ns after each edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         check("model", {5'b0, io.sensor_sync, io.walk_request_sync, io.reprogram_sync},
               {5'b0, m_level[0], m_pulse[1], m_pulse[2]});
         if (io.walk_request_sync === 1'b1) walk_pulses++;
         if (io.reprogram_sync === 1'b1) rep_pulses++;
         #1;
      end
   endtask

   initial begin
      // 1: inputs high during reset, then release
      io.sensor = 1'b1; io.walk_request = 1'b1; io.reprogram = 1'b1;
      tick(3);
      check("rst_sensor", {7'b0, io.sensor_sync}, 8'd0);
      check("rst_walk",   {7'b0, io.walk_request_sync}, 8'd0);
      check("rst_rep",    {7'b0, io.reprogram_sync}, 8'd0);
      reset = 1'b1;
      tick(5);
      check("t1_early", {5'b0, io.sensor_sync, io.walk_request_sync, io.reprogram_sync}, 8'd0);
      tick(1);
      check("t1_edge6", {5'b0, io.sensor_sync, io.walk_request_sync, io.reprogram_sync}, 8'd7);
      tick(1);
      check("t1_edge7", {5'b0, io.sensor_sync, io.walk_request_sync, io.reprogram_sync}, 8'd4);
      io.sensor = 1'b0; io.walk_request = 1'b0; io.reprogram = 1'b0;
      tick(8);
      check("t1_released", {7'b0, io.sensor_sync}, 8'd0);
      check("t1_walk_cnt", 8'(walk_pulses), 8'd1);

      // 2: press too short to be accepted
      io.walk_request = 1'b1;
      tick(3);
      io.walk_request = 1'b0;
      tick(10);
      check("t2_walk_cnt", 8'(walk_pulses), 8'd1);

      // 3: long press -> single pulse after E0+5
      io.walk_request = 1'b1;
      tick(5);
      check("t3_before", {7'b0, io.walk_request_sync}, 8'd0);
      tick(1);
      check("t3_pulse", {7'b0, io.walk_request_sync}, 8'd1);
      tick(1);
      check("t3_after", {7'b0, io.walk_request_sync}, 8'd0);
      tick(13);
      io.walk_request = 1'b0;
      tick(10);
      check("t3_walk_cnt", 8'(walk_pulses), 8'd2);

      // 4: chatter on sensor never gets through, then steady high/low
      for (int i = 0; i < 30; i++) begin
         io.sensor = ((i / 2) % 2) != 0;
         tick(1);
         check("t4_toggle", {7'b0, io.sensor_sync}, 8'd0);
      end
      io.sensor = 1'b1;
      tick(5);
      check("t4_rise_early", {7'b0, io.sensor_sync}, 8'd0);
      tick(1);
      check("t4_rise", {7'b0, io.sensor_sync}, 8'd1);
      tick(4);
      io.sensor = 1'b0;
      tick(5);
      check("t4_fall_early", {7'b0, io.sensor_sync}, 8'd1);
      tick(1);
      check("t4_fall", {7'b0, io.sensor_sync}, 8'd0);

      // 5: simultaneous presses
      io.walk_request = 1'b1; io.reprogram = 1'b1;
      tick(5);
      check("t5_early", {6'b0, io.walk_request_sync, io.reprogram_sync}, 8'd0);
      tick(1);
      check("t5_both", {6'b0, io.walk_request_sync, io.reprogram_sync}, 8'd3);
      tick(4);
      io.walk_request = 1'b0; io.reprogram = 1'b0;
      tick(10);
      check("t5_walk_cnt", 8'(walk_pulses), 8'd3);
      check("t5_rep_cnt",  8'(rep_pulses), 8'd2);

      // 6: reset while reprogram is mid-confirmation (count 2)
      io.reprogram = 1'b1;
      tick(4);
      reset = 1'b0;
      #1;
      check("t6_in_reset", {7'b0, io.reprogram_sync}, 8'd0);
      #2;
      reset = 1'b1;
      tick(5);
      check("t6_early", {7'b0, io.reprogram_sync}, 8'd0);
      check("t6_rep_cnt_pre", 8'(rep_pulses), 8'd2);
      tick(1);
      check("t6_pulse", {7'b0, io.reprogram_sync}, 8'd1);
      tick(1);
      check("t6_after", {7'b0, io.reprogram_sync}, 8'd0);
      io.reprogram = 1'b0;
      tick(10);
      check("t6_rep_cnt", 8'(rep_pulses), 8'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
